// File: rtl/wb_bus_pkg.sv
// Shared Wishbone bridge definitions: FSM states, default slave regions, select constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Default slave region indices on the reference SoC map.
  localparam int REGION_RAM      = 0;
  localparam int REGION_GPIO_IN  = 1;
  localparam int REGION_GPIO_OUT = 2;
  localparam int REGION_PWM      = 3;

  // All-lanes byte select; users slice the low DATA_W/8 bits (buses up to 512 bits).
  localparam int SEL_MAX_W = 64;
  localparam logic [SEL_MAX_W-1:0] SEL_ALL = '1;

endpackage

// File: rtl/wb_addr_decode.sv
// Address-region decoder: maps a byte address to slave index, one-hot select and hit flag.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   addr   - byte address to decode
//   index  - slave index taken from addr[REGION_LSB +: clog2(N_SLAVES)]
//   onehot - one-hot slave select, all-zero on a miss
//   hit    - address lands in a populated region and all bits above the field are zero
module wb_addr_decode #(
  parameter int ADDR_W     = 32,
  parameter int N_SLAVES   = 4,
  parameter int REGION_LSB = 8,
  parameter int IDX_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [IDX_W-1:0]    index,
  output logic [N_SLAVES-1:0] onehot,
  output logic                hit
);

  // Width of the index field inside the address; zero for a single slave.
  localparam int FIELD_W = $clog2(N_SLAVES);

  logic [ADDR_W-1:0] region;
  logic              upper_zero;
  logic              in_range;

  assign region     = addr >> REGION_LSB;
  assign upper_zero = ((region >> FIELD_W) == '0);

  if (FIELD_W == 0) begin : g_single
    assign index    = '0;
    assign in_range = 1'b1;
  end else begin : g_multi
    assign index    = region[IDX_W-1:0];
    // Non-power-of-two slave counts leave unpopulated indices at the top.
    assign in_range = (32'(index) < 32'(N_SLAVES));
  end

  assign hit = upper_zero && in_range;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      onehot[i] = hit && (32'(index) == 32'(i));
    end
  end

endmodule

// File: rtl/wb_master_bridge.sv
// CPU-to-Wishbone classic master bridge with region decode, ERR_I and decode-miss errors.
// Latency: request-to-ready 2 cycles minimum (+1 per slave wait state); decode miss 2 cycles.
// Backpressure: one outstanding request; CPU strobes are ignored until cpu_ready pulses.
//
// Ports:
//   clk, reset                      - clock, async active-high reset
//   cpu_addr/data_write/be          - CPU request payload, captured in IDLE
//   cpu_read, cpu_write             - request strobes (write wins when both high)
//   cpu_data_read, cpu_ready, cpu_err - registered response; ready is a one-cycle pulse
//   ADR_O..CYC_O, DAT_I/ACK_I/ERR_I - Wishbone classic master side
//   slave_sel                       - one-hot slave select, high only with CYC_O
//
// Build option: define WB_BRIDGE_TIMEOUT_EN to add the bus watchdog (TIMEOUT cycles);
// without it BUS waits indefinitely for ACK_I/ERR_I.
module wb_master_bridge
  import wb_bus_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int N_SLAVES   = 4,
  parameter int REGION_LSB = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_data_write,
  input  logic [DATA_W/8-1:0]   cpu_be,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  output logic [DATA_W-1:0]     cpu_data_read,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [ADDR_W-1:0]     ADR_O,
  output logic [DATA_W-1:0]     DAT_O,
  output logic [DATA_W/8-1:0]   SEL_O,
  output logic                  WE_O,
  output logic                  STB_O,
  output logic                  CYC_O,
  input  logic [DATA_W-1:0]     DAT_I,
  input  logic                  ACK_I,
  input  logic                  ERR_I,
  output logic [N_SLAVES-1:0]   slave_sel
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  if ((DATA_W % 8) != 0 || DATA_W > 8 * SEL_MAX_W || N_SLAVES < 1 || N_SLAVES > 16 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("wb_master_bridge: parameter out of range");
  end

  state_t               state;
  logic                 req;
  logic                 bus_hit;
  logic                 dec_hit;
  logic [IDX_W-1:0]     dec_index;
  logic [N_SLAVES-1:0]  dec_onehot;
  logic                 wdog_expire;

  wb_addr_decode #(
    .ADDR_W     (ADDR_W),
    .N_SLAVES   (N_SLAVES),
    .REGION_LSB (REGION_LSB),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr   (cpu_addr),
    .index  (dec_index),
    .onehot (dec_onehot),
    .hit    (dec_hit)
  );

  assign req = cpu_read | cpu_write;
  // The select bit at the decoded index must agree with hit before a cycle is started.
  assign bus_hit = dec_hit && dec_onehot[dec_index];

`ifdef WB_BRIDGE_TIMEOUT_EN
  logic [7:0] wdog;

  // Counts BUS edges with no response; expiry fires on the TIMEOUT-th such edge.
  assign wdog_expire = (wdog == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog <= '0;
    end else if (state == ST_BUS && !ACK_I && !ERR_I && !wdog_expire) begin
      wdog <= wdog + 8'd1;
    end else begin
      wdog <= '0;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      ADR_O         <= '0;
      DAT_O         <= '0;
      SEL_O         <= '0;
      WE_O          <= 1'b0;
      STB_O         <= 1'b0;
      CYC_O         <= 1'b0;
      slave_sel     <= '0;
      cpu_ready     <= 1'b0;
      cpu_err       <= 1'b0;
      cpu_data_read <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            ADR_O <= cpu_addr;
            DAT_O <= cpu_data_write;
            SEL_O <= (cpu_be == '0) ? SEL_ALL[BE_W-1:0] : cpu_be;
            WE_O  <= cpu_write;
            if (bus_hit) begin
              CYC_O     <= 1'b1;
              STB_O     <= 1'b1;
              slave_sel <= dec_onehot;
              state     <= ST_BUS;
            end else begin
              // Miss: RESP is entered with ready low and raises it one edge later,
              // so a miss completes with the same latency as a zero-wait hit.
              state <= ST_RESP;
            end
          end
        end

        ST_BUS: begin
          if (ERR_I || ACK_I || wdog_expire) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            slave_sel <= '0;
            cpu_ready <= 1'b1;
            cpu_err   <= ERR_I || !ACK_I;
            if (ACK_I && !ERR_I && !WE_O) begin
              cpu_data_read <= DAT_I;
            end
            state <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (cpu_ready) begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            // Only the decode-miss path arrives here with ready still low.
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed self-checking bench for wb_master_bridge (default parameters).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_wb_master_bridge;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int N_SLAVES   = 4;
  localparam int REGION_LSB = 8;
  localparam int TIMEOUT    = 15;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W-1:0]   cpu_data_write;
  logic [DATA_W/8-1:0] cpu_be;
  logic                cpu_read;
  logic                cpu_write;
  logic [DATA_W-1:0]   cpu_data_read;
  logic                cpu_ready;
  logic                cpu_err;
  logic [ADDR_W-1:0]   ADR_O;
  logic [DATA_W-1:0]   DAT_O;
  logic [DATA_W/8-1:0] SEL_O;
  logic                WE_O;
  logic                STB_O;
  logic                CYC_O;
  logic [DATA_W-1:0]   DAT_I;
  logic                ACK_I;
  logic                ERR_I;
  logic [N_SLAVES-1:0] slave_sel;

  int checks = 0;
  int passes = 0;
  logic [DATA_W-1:0] exp_rdata;

  always #5 clk = ~clk;

  wb_master_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SLAVES(N_SLAVES),
    .REGION_LSB(REGION_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data_write(cpu_data_write), .cpu_be(cpu_be),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_data_read(cpu_data_read), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I),
    .slave_sel(slave_sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_addr = '0; cpu_data_write = '0; cpu_be = 4'hF;
    cpu_read = 1'b0; cpu_write = 1'b0;
    DAT_I = '0; ACK_I = 1'b0; ERR_I = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({CYC_O, STB_O, WE_O} !== 3'b000) $display("FAIL reset_ctrl got=%b exp=000", {CYC_O, STB_O, WE_O}); else passes++;
    checks++; if ({SEL_O, slave_sel} !== 8'h00) $display("FAIL reset_sel got=%h exp=00", {SEL_O, slave_sel}); else passes++;
    checks++; if ({cpu_ready, cpu_err} !== 2'b00) $display("FAIL reset_resp got=%b exp=00", {cpu_ready, cpu_err}); else passes++;
    checks++; if (cpu_data_read !== 32'h0 || ADR_O !== 32'h0 || DAT_O !== 32'h0) $display("FAIL reset_data rd=%h adr=%h dat=%h exp=0", cpu_data_read, ADR_O, DAT_O); else passes++;
    reset = 1'b0;
    exp_rdata = 32'h0;
    tick(); tick();
    checks++; if ({CYC_O, cpu_ready} !== 2'b00) $display("FAIL idle_quiet got=%b exp=00", {CYC_O, cpu_ready}); else passes++;
  endtask

  task automatic test_read_zero_wait();
    cpu_addr = 32'h104; cpu_be = 4'hF; cpu_read = 1'b1;
    DAT_I = 32'hA5A5_0001; ACK_I = 1'b1;
    tick();  // edge N
    cpu_read = 1'b0;
    checks++; if ({CYC_O, STB_O, WE_O} !== 3'b110) $display("FAIL rd_bus_ctrl got=%b exp=110", {CYC_O, STB_O, WE_O}); else passes++;
    checks++; if (slave_sel !== 4'b0010) $display("FAIL rd_slave_sel got=%b exp=0010", slave_sel); else passes++;
    checks++; if (ADR_O !== 32'h104 || SEL_O !== 4'hF) $display("FAIL rd_adr_sel adr=%h sel=%h exp=104/f", ADR_O, SEL_O); else passes++;
    checks++; if (cpu_ready !== 1'b0) $display("FAIL rd_early_ready got=%b exp=0", cpu_ready); else passes++;
    tick();  // edge N+1
    ACK_I = 1'b0;
    checks++; if ({cpu_ready, cpu_err} !== 2'b10) $display("FAIL rd_resp got=%b exp=10", {cpu_ready, cpu_err}); else passes++;
    exp_rdata = 32'hA5A5_0001;
    checks++; if (cpu_data_read !== exp_rdata) $display("FAIL rd_data got=%h exp=%h", cpu_data_read, exp_rdata); else passes++;
    checks++; if ({CYC_O, STB_O, slave_sel} !== 6'b0) $display("FAIL rd_release got=%b exp=000000", {CYC_O, STB_O, slave_sel}); else passes++;
    tick();  // edge N+2
    checks++; if (cpu_ready !== 1'b0) $display("FAIL rd_ready_pulse got=%b exp=0", cpu_ready); else passes++;
  endtask

  task automatic test_write_wait_states();
    cpu_addr = 32'h208; cpu_data_write = 32'hDEAD_BEEF; cpu_be = 4'b0011; cpu_write = 1'b1;
    ACK_I = 1'b0;
    tick();  // edge N
    // A new request while the bus is busy must not disturb the cycle.
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 32'h0; cpu_data_write = 32'h0; cpu_be = 4'hF;
    checks++; if (SEL_O !== 4'b0011 || WE_O !== 1'b1) $display("FAIL wr_sel_we sel=%b we=%b exp=0011/1", SEL_O, WE_O); else passes++;
    checks++; if (slave_sel !== 4'b0100) $display("FAIL wr_slave_sel got=%b exp=0100", slave_sel); else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (STB_O !== 1'b1 || DAT_O !== 32'hDEAD_BEEF || ADR_O !== 32'h208 || cpu_ready !== 1'b0)
        $display("FAIL wr_hold[%0d] stb=%b dat=%h adr=%h rdy=%b exp=1/deadbeef/208/0", k, STB_O, DAT_O, ADR_O, cpu_ready);
      else passes++;
      if (k == 3) begin
        cpu_read = 1'b0;
        ACK_I = 1'b1;
      end
      tick();
    end
    // now after edge N+4
    ACK_I = 1'b0;
    checks++; if ({cpu_ready, cpu_err, STB_O} !== 3'b100) $display("FAIL wr_resp got=%b exp=100", {cpu_ready, cpu_err, STB_O}); else passes++;
    checks++; if (cpu_data_read !== exp_rdata) $display("FAIL wr_rdata_kept got=%h exp=%h", cpu_data_read, exp_rdata); else passes++;
    tick(); tick();
    checks++; if ({CYC_O, cpu_ready} !== 2'b00) $display("FAIL wr_ignored_req got=%b exp=00", {CYC_O, cpu_ready}); else passes++;
  endtask

  task automatic test_decode_miss();
    logic [31:0] miss_addr [2];
    miss_addr[0] = 32'h0001_0000;
    miss_addr[1] = 32'h0000_0400;  // first byte past the top region
    for (int i = 0; i < 2; i++) begin
      cpu_addr = miss_addr[i]; cpu_read = 1'b1; ACK_I = 1'b1;
      tick();  // edge N
      cpu_read = 1'b0;
      checks++; if ({CYC_O, cpu_ready} !== 2'b00) $display("FAIL miss%0d_n got=%b exp=00", i, {CYC_O, cpu_ready}); else passes++;
      tick();  // edge N+1
      checks++; if ({cpu_ready, cpu_err, CYC_O} !== 3'b110) $display("FAIL miss%0d_resp got=%b exp=110", i, {cpu_ready, cpu_err, CYC_O}); else passes++;
      tick();
      ACK_I = 1'b0;
      checks++; if ({cpu_ready, CYC_O} !== 2'b00) $display("FAIL miss%0d_end got=%b exp=00", i, {cpu_ready, CYC_O}); else passes++;
    end
    checks++; if (cpu_data_read !== exp_rdata) $display("FAIL miss_rdata got=%h exp=%h", cpu_data_read, exp_rdata); else passes++;
  endtask

  task automatic test_err_and_ack();
    cpu_addr = 32'h3FF; cpu_read = 1'b1;
    DAT_I = 32'hFFFF_0000; ACK_I = 1'b1; ERR_I = 1'b1;
    tick();
    cpu_read = 1'b0;
    checks++; if (slave_sel !== 4'b1000) $display("FAIL err_slave_sel got=%b exp=1000", slave_sel); else passes++;
    tick();
    ACK_I = 1'b0; ERR_I = 1'b0;
    checks++; if ({cpu_ready, cpu_err} !== 2'b11) $display("FAIL err_resp got=%b exp=11", {cpu_ready, cpu_err}); else passes++;
    checks++; if (cpu_data_read !== exp_rdata) $display("FAIL err_rdata got=%h exp=%h", cpu_data_read, exp_rdata); else passes++;
    tick();
  endtask

  task automatic test_be_zero_write_wins();
    cpu_addr = 32'h004; cpu_data_write = 32'h0000_00FF; cpu_be = 4'b0000;
    cpu_read = 1'b1; cpu_write = 1'b1;
    DAT_I = 32'hCAFE_CAFE; ACK_I = 1'b1;
    tick();
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_be = 4'hF;
    checks++; if ({WE_O, SEL_O} !== 5'b1_1111) $display("FAIL bez_we_sel got=%b exp=11111", {WE_O, SEL_O}); else passes++;
    checks++; if (slave_sel !== 4'b0001) $display("FAIL bez_slave_sel got=%b exp=0001", slave_sel); else passes++;
    tick();
    ACK_I = 1'b0;
    checks++; if ({cpu_ready, cpu_err} !== 2'b10 || cpu_data_read !== exp_rdata) $display("FAIL bez_resp rdy_err=%b rd=%h exp=10/%h", {cpu_ready, cpu_err}, cpu_data_read, exp_rdata); else passes++;
    tick();
  endtask

  task automatic test_timeout();
    cpu_addr = 32'h000; cpu_read = 1'b1; ACK_I = 1'b0; ERR_I = 1'b0;
    tick();  // edge N
    cpu_read = 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
    begin
      int hi = 0;
      for (int k = 0; k < 40 && STB_O === 1'b1; k++) begin
        hi++;
        tick();
      end
      checks++; if (hi != TIMEOUT) $display("FAIL wdog_cycles got=%0d exp=%0d", hi, TIMEOUT); else passes++;
      checks++; if ({cpu_ready, cpu_err, CYC_O} !== 3'b110) $display("FAIL wdog_resp got=%b exp=110", {cpu_ready, cpu_err, CYC_O}); else passes++;
      DAT_I = 32'h5555_AAAA; ACK_I = 1'b1;  // late ack
      tick();
      ACK_I = 1'b0;
      checks++; if ({cpu_ready, CYC_O} !== 2'b00 || cpu_data_read !== exp_rdata) $display("FAIL wdog_late_ack rdy_cyc=%b rd=%h exp=00/%h", {cpu_ready, CYC_O}, cpu_data_read, exp_rdata); else passes++;
    end
`else
    repeat (100) tick();
    checks++; if ({STB_O, CYC_O, cpu_ready} !== 3'b110) $display("FAIL nowdog_hold got=%b exp=110", {STB_O, CYC_O, cpu_ready}); else passes++;
    DAT_I = 32'h1234_5678; ACK_I = 1'b1;
    tick();
    ACK_I = 1'b0;
    exp_rdata = 32'h1234_5678;
    checks++; if ({cpu_ready, cpu_err} !== 2'b10 || cpu_data_read !== exp_rdata) $display("FAIL nowdog_resp rdy_err=%b rd=%h exp=10/%h", {cpu_ready, cpu_err}, cpu_data_read, exp_rdata); else passes++;
`endif
    tick();
  endtask

  task automatic test_reset_mid_bus();
    cpu_addr = 32'h100; cpu_read = 1'b1; ACK_I = 1'b0;
    tick();
    cpu_read = 1'b0;
    checks++; if (CYC_O !== 1'b1) $display("FAIL rst_bus_entry got=%b exp=1", CYC_O); else passes++;
    #3;
    reset = 1'b1;
    #1;  // no clock edge since reset rose
    checks++; if ({CYC_O, STB_O, slave_sel} !== 6'b0) $display("FAIL rst_async_drop got=%b exp=000000", {CYC_O, STB_O, slave_sel}); else passes++;
    DAT_I = 32'h0BAD_F00D; ACK_I = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (cpu_ready !== 1'b0) $display("FAIL rst_no_ready[%0d] got=%b exp=0", k, cpu_ready); else passes++;
    end
    reset = 1'b0;
    ACK_I = 1'b0;
    exp_rdata = 32'h0;
    tick();
    checks++; if ({cpu_ready, CYC_O} !== 2'b00 || cpu_data_read !== exp_rdata) $display("FAIL rst_after rdy_cyc=%b rd=%h exp=00/%h", {cpu_ready, CYC_O}, cpu_data_read, exp_rdata); else passes++;
    cpu_addr = 32'h104; cpu_read = 1'b1; ACK_I = 1'b1;
    tick();
    cpu_read = 1'b0;
    tick();
    ACK_I = 1'b0;
    exp_rdata = 32'h0BAD_F00D;
    checks++; if ({cpu_ready, cpu_err} !== 2'b10 || cpu_data_read !== exp_rdata) $display("FAIL rst_next_req rdy_err=%b rd=%h exp=10/%h", {cpu_ready, cpu_err}, cpu_data_read, exp_rdata); else passes++;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait_states();
    test_decode_miss();
    test_err_and_ack();
    test_be_zero_write_wins();
    test_timeout();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not complete, checks=%0d", checks);
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Parametrised CPU-to-Wishbone master bridge and the successor to the single-master bus block. It registers each CPU request, decodes the target slave from a configurable address-region field, and runs one Wishbone classic cycle. It returns read data or an error with a one-cycle `cpu_ready` pulse. New relative to the previous generation: per-byte enables, one-hot slave selects, `ERR_I` handling, a decode-miss error, and an optional bus watchdog.

## Interface
- `DATA_W`, default 32: data bus width; must be a multiple of 8.
- `ADDR_W`, default 32: address width.
- `N_SLAVES`, default 4: number of decoded slaves, 1..16.
- `REGION_LSB`, default 8: lowest address bit of the slave index; each region spans 2^REGION_LSB bytes.
- `TIMEOUT`, default 15: cycles `STB_O` may stay high without `ACK_I`/`ERR_I`; range 1..255.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `cpu_addr`, in, ADDR_W: byte address.
- `cpu_data_write`, in, DATA_W: write data.
- `cpu_be`, in, DATA_W/8: byte enables.
- `cpu_read`, `cpu_write`, in, 1: request strobes; sampled only in IDLE.
- `cpu_data_read`, out, DATA_W: registered read data.
- `cpu_ready`, out, 1: one-cycle completion pulse.
- `cpu_err`, out, 1: valid together with `cpu_ready`.
- `ADR_O`, out, ADDR_W; `DAT_O`, out, DATA_W; `SEL_O`, out, DATA_W/8; `WE_O`, `STB_O`, `CYC_O`, out, 1: Wishbone master outputs.
- `DAT_I`, in, DATA_W; `ACK_I`, `ERR_I`, in, 1: Wishbone slave responses.
- `slave_sel`, out, N_SLAVES: one-hot slave select, high only while `CYC_O` is high.

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - On `cpu_read|cpu_write`, capture addr, wdata, be and we. If both strobes are high, write wins.
  - Decode index = `cpu_addr[REGION_LSB +: clog2(N_SLAVES)]`. A hit also requires all bits above the field to be 0.
  - Hit: go to BUS. Miss: go to RESP with err=1; no bus cycle is issued.
- BUS: `CYC_O`=`STB_O`=1. `ADR_O`, `DAT_O`, `SEL_O` (=captured be; all-zero be is forced to all-ones) and `WE_O` come from the capture registers and stay stable until the cycle ends.
- BUS exit conditions (priority order):
  - `ERR_I` → RESP with err=1.
  - else `ACK_I` → RESP with err=0; on a read, `cpu_data_read` is loaded from `DAT_I`.
  - else watchdog expiry → RESP with err=1.
- RESP: `cpu_ready`=1 for exactly one cycle, `cpu_err` per the captured result, then IDLE. `cpu_data_read` holds its value until the next read completion. Errored reads leave it unchanged.
- Requests arriving outside IDLE are ignored. The CPU must wait for `cpu_ready` before issuing the next request.

## Timing
- All outputs are registered. Reset values: all Wishbone outputs 0, `SEL_O`=0, `slave_sel`=0, `cpu_ready`=0, `cpu_err`=0, `cpu_data_read`=0, state=IDLE, watchdog=0.
- Request sampled at edge N → `STB_O` high from N.
- Zero-wait slave: `ACK_I` sampled at edge N+1 → `STB_O` low and `cpu_ready` high after N+1 → back in IDLE at N+2. Minimum request-to-ready latency is 2 cycles; each slave wait state adds 1.
- Decode miss: `cpu_ready` after edge N+1, `CYC_O` never asserted.
- Watchdog counts BUS cycles without a response. On the TIMEOUT-th such edge the bridge drops `CYC_O`/`STB_O` and enters RESP. A late `ACK_I` in RESP/IDLE is ignored.
- `reset` asserted mid-cycle immediately drops `CYC_O`/`STB_O`; the pending transaction is discarded with no `cpu_ready`.

## Configuration
- `WB_BRIDGE_TIMEOUT_EN` defined: watchdog counter present; behaviour as above.
- Not defined: no counter, and BUS waits indefinitely for `ACK_I`/`ERR_I`. The `TIMEOUT` parameter is accepted but unused.

## Structure
- Shared package `wb_bus_pkg` holds:
  - the state enum,
  - the default region constants (RAM=0, GPIO_IN=1, GPIO_OUT=2, PWM=3),
  - a `SEL_ALL` helper constant.
- Sub-module `wb_addr_decode`: combinational address-to-index/one-hot/hit decode, parametrised by `ADDR_W`, `N_SLAVES` and `REGION_LSB`. It is reusable by the interconnect.

## Test plan
- Read 0x104 with a slave that acks at the next edge and DAT_I=0xA5A5_0001 → `cpu_ready` 2 cycles after the request, `cpu_data_read`=0xA5A5_0001, `slave_sel`=0010, `cpu_err`=0.
- Write 0x208, data 0xDEAD_BEEF, be=0011, slave with 3 wait states → `SEL_O`=0011, `WE_O`=1, `DAT_O` stable for 4 cycles, `cpu_ready` at request+5.
- Read 0x1_0000 (decode miss) → `CYC_O` stays 0, `cpu_ready` and `cpu_err`=1 at request+1 edge.
- With the macro defined, TIMEOUT=15, slave never acks → bus released after 15 cycles, `cpu_err`=1. Without the macro, `STB_O` is still high after 100 cycles.
- `ERR_I` and `ACK_I` asserted together on a read → `cpu_err`=1, `cpu_data_read` unchanged.
- Assert `reset` while in BUS → `CYC_O`/`STB_O` go to 0 asynchronously, no `cpu_ready`, and the next request completes normally.
